// File: rtl/sram_banked_model_pkg.sv
// Shared constants and elaboration helpers for the banked SRAM model.
// No ports; imported by sram_rd_pipe and sram_banked_model.
package sram_banked_model_pkg;

    localparam int LANE_W     = 8;
    localparam int MIN_LAT    = 1;
    localparam int MAX_LAT    = 4;
    localparam int DATA_W_DEF = 16;
    localparam int LANES      = DATA_W_DEF / LANE_W;

    // Default-width read-pipeline stage. The modules declare the same
    // layout at their own DATA_W so the model stays width-generic.
    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] data;
        logic [LANES-1:0]      mask;
    } rd_stage_t;

    function automatic int lanes_of(input int data_w);
        return data_w / LANE_W;
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat >= MIN_LAT) && (lat <= MAX_LAT);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// READ_LAT-deep shift register of read stages {valid, data, mask}.
// Ports: clk, rst_n, stg_i (stage entering), stg_o (output stage).
module sram_rd_pipe
    import sram_banked_model_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LANES    = 2,
    parameter int READ_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W+LANES:0] stg_i,
    output logic [DATA_W+LANES:0] stg_o
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  mask;
    } stage_t;

    stage_t            in_s;
    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [READ_LAT];
    logic [LANES-1:0]  msk_q [READ_LAT];

    assign in_s = stg_i;

    // Only the valid bits are reset; payload is don't-care when invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_s.valid;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_s.data;
        msk_q[0] <= in_s.mask;
        for (int i = 1; i < READ_LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
            msk_q[i] <= msk_q[i-1];
        end
    end

    assign stg_o = {vld_q[READ_LAT-1], dat_q[READ_LAT-1], msk_q[READ_LAT-1]};

endmodule

// File: rtl/sram_banked_model.sv
// Byte-lane SRAM model with pipelined reads, OE/tri-state and OOB flag.
// Ports: clk, rst_n, SRAM_ADDR/BE_N/WE_N/CE_N/OE_N, SRAM_DQ, rd_valid, oob.
module sram_banked_model
    import sram_banked_model_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 18,
    parameter int DEPTH    = 2048,
    parameter int READ_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      SRAM_ADDR,
    input  logic [DATA_W/8-1:0]    SRAM_BE_N,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_OE_N,
    inout  wire  [DATA_W-1:0]      SRAM_DQ,
    output logic                   rd_valid,
    output logic                   oob
);

    localparam int NL    = lanes_of(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
        $error("READ_LAT must be in 1..4");
    end
    if ((DATA_W % LANE_W) != 0) begin : g_bad_dw
        $error("DATA_W must be a multiple of 8");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $error("DEPTH exceeds address space");
    end

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [NL-1:0]     mask;
    } stage_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run_q;
    logic              oob_q;
    logic              oob_d;
    logic              req;
    logic              rd_req;
    logic              wr_req;
    logic              wr_cyc;
    logic              in_rng;
    logic [IDX_W-1:0]  idx;
    logic [NL-1:0]     drv;
    stage_t            push;
    stage_t            pop;

    assign req    = !SRAM_CE_N && (SRAM_BE_N != '1);
    assign rd_req = req && SRAM_WE_N;
    assign wr_req = req && !SRAM_WE_N;
    // Bus turnaround guard: never drive while the master may be writing.
    assign wr_cyc = !SRAM_CE_N && !SRAM_WE_N;
    assign in_rng = {1'b0, SRAM_ADDR} < DEPTH_V;
    assign idx    = SRAM_ADDR[IDX_W-1:0];

    // Low through the reset-release edge, so a write there is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Contents survive reset by design.
    always_ff @(posedge clk) begin
        if (run_q && wr_req && in_rng) begin
            for (int i = 0; i < NL; i++) begin
                if (!SRAM_BE_N[i]) begin
                    mem_q[idx][i*LANE_W +: LANE_W] <= SRAM_DQ[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        push       = '0;
        push.valid = rd_req;
        push.mask  = ~SRAM_BE_N;
        push.data  = in_rng ? mem_q[idx] : '0;
    end

    sram_rd_pipe #(
        .DATA_W   (DATA_W),
        .LANES    (NL),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .stg_i (push),
        .stg_o (pop)
    );

    assign oob_d = req && !in_rng;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign drv = (pop.valid && !SRAM_OE_N && !wr_cyc) ? pop.mask : '0;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign SRAM_DQ[g*LANE_W +: LANE_W] =
            drv[g] ? pop.data[g*LANE_W +: LANE_W] : {LANE_W{1'bz}};
    end

    assign rd_valid = pop.valid;
    assign oob      = oob_q;

endmodule

// File: tb/tb_sram_banked_model.sv
// Scoreboard bench for sram_banked_model: random + directed traffic.
// Undriven DQ bits are pulled up, so a released lane reads as 8'hFF.
module tb_sram_banked_model;

    localparam int DW    = 16;
    localparam int AW    = 18;
    localparam int DEPTH = 2048;
    localparam int LAT   = 3;
    localparam int LN    = DW / 8;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [LN-1:0] mask;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [AW-1:0] addr   = '0;
    logic [LN-1:0] be_n   = '1;
    logic          we_n   = 1'b1;
    logic          ce_n   = 1'b1;
    logic          oe_n   = 1'b0;
    logic          drv_en = 1'b0;
    logic [DW-1:0] tb_dq  = '0;
    wire  [DW-1:0] dq;
    logic          rd_valid;
    logic          oob;

    int            n_vec = 0;
    int            n_bad = 0;
    int            edge_cnt = 0;
    logic [DW-1:0] mdl [DEPTH];
    exp_t          sbq [$];
    bit            oob_at [int];

    assign dq = drv_en ? tb_dq : {DW{1'bz}};

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup pu (dq[g]);
    end

    sram_banked_model #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .READ_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SRAM_ADDR (addr),
        .SRAM_BE_N (be_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_DQ   (dq),
        .rd_valid  (rd_valid),
        .oob       (oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic void chk(input string nm,
                                input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h, want %h",
                     nm, edge_cnt, act, exp);
        end
    endfunction

    // One bus cycle; inputs are set just after a posedge and sampled at
    // the next one. The model is updated at issue time.
    task automatic op(input bit ce, input bit wr,
                      input logic [AW-1:0] a, input logic [LN-1:0] be,
                      input logic [DW-1:0] d, input bit oe);
        exp_t e;
        int   ai;
        ai     = int'(a);
        ce_n   = !ce;
        we_n   = !wr;
        addr   = a;
        be_n   = be;
        oe_n   = !oe;
        drv_en = ce && wr;
        tb_dq  = d;
        if (ce && be != '1) begin
            if (ai >= DEPTH) oob_at[edge_cnt + 1] = 1'b1;
            if (wr) begin
                if (ai < DEPTH) begin
                    for (int i = 0; i < LN; i++) begin
                        if (!be[i]) mdl[ai][i*8 +: 8] = d[i*8 +: 8];
                    end
                end
            end else begin
                e.due  = edge_cnt + LAT;
                e.data = (ai < DEPTH) ? mdl[ai] : '0;
                e.mask = ~be;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d,
                      input logic [LN-1:0] be = '0);
        op(1'b1, 1'b1, AW'(a), be, d, 1'b1);
    endtask

    task automatic rd(input int a, input logic [LN-1:0] be = '0,
                      input bit oe = 1'b1);
        op(1'b1, 1'b0, AW'(a), be, '0, oe);
    endtask

    task automatic idle(input bit oe = 1'b1);
        op(1'b0, 1'b0, '0, '1, '0, oe);
    endtask

    // Monitor: at each negedge compare rd_valid, oob and the bus.
    initial begin
        exp_t          e;
        bit            ev;
        bit            wcyc;
        logic [DW-1:0] xdq;
        forever begin
            @(negedge clk);
            ev   = (sbq.size() > 0) && (sbq[0].due == edge_cnt);
            wcyc = !ce_n && !we_n;
            chk("rd_valid", DW'(rd_valid), DW'(ev));
            chk("oob", DW'(oob), DW'(oob_at.exists(edge_cnt)));
            xdq = '1;
            if (ev) begin
                e = sbq.pop_front();
                for (int i = 0; i < LN; i++) begin
                    if (e.mask[i] && !oe_n) xdq[i*8 +: 8] = e.data[i*8 +: 8];
                end
            end
            if (wcyc) xdq = tb_dq;
            chk("dq", dq, xdq);
        end
    end

    initial begin
        int            r;
        int            a;
        logic [LN-1:0] be;
        bit            oe;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_valid", DW'(rd_valid), '0);
        chk("reset_oob", DW'(oob), '0);
        chk("reset_dq", dq, '1);
        rst_n = 1'b1;
        idle();
        idle();

        for (int i = 0; i < 64; i++) wr(i, DW'($urandom));
        wr(2047, DW'($urandom));
        for (int i = 0; i < 4; i++) wr(i, DW'(16'h1000 + i));
        wr(7, 16'h0001);

        wr(5, 16'hA5C3, 2'b00);
        wr(5, 16'hFF11, 2'b10);
        rd(5);

        for (int i = 0; i < 4; i++) rd(i);

        rd(5, 2'b01);
        rd(5, 2'b01);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);

        rd(7);
        wr(7, 16'hBEEF);
        rd(7);

        wr(2048, 16'h5A5A);
        rd(2048);
        rd(0);
        rd(2047);
        repeat (LAT) idle();

        rd(1);
        rd(2);
        rd(3);
        ce_n   = 1'b1;
        we_n   = 1'b1;
        drv_en = 1'b0;
        be_n   = '1;
        oe_n   = 1'b0;
        rst_n  = 1'b0;
        sbq.delete();
        oob_at.delete();
        #1;
        chk("midrst_rd_valid", DW'(rd_valid), '0);
        chk("midrst_dq", dq, '1);
        chk("midrst_oob", DW'(oob), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        rd(1);
        rd(2);
        rd(5);
        repeat (LAT + 1) idle();

        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 99);
            a  = ($urandom_range(0, 19) == 0) ?
                 DEPTH + $urandom_range(0, 3) : $urandom_range(0, 63);
            be = LN'($urandom_range(0, 3));
            oe = ($urandom_range(0, 3) != 0);
            if (r < 50) op(1'b1, 1'b0, AW'(a), be, '0, oe);
            else if (r < 85) op(1'b1, 1'b1, AW'(a), be, DW'($urandom), oe);
            else idle(oe);
        end

        repeat (LAT + 2) idle();
        chk("drain_queue", DW'(sbq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_banked_model.md
# sram_banked_model

Parametrised, byte-lane-aware, pipelined-read SRAM model, the next generation of the memory model behind the SRAM controller of the ARM processor test system.
- Replaces the fixed 16-bit, single-cycle-read model.
- Generalised in data width, depth and read latency.
- Adds per-lane tri-state, output enable, out-of-range detection and a read-valid strobe so the controller and benches can check access timing.

## Interface
Parameters:
- DATA_W, 16, data bus width; multiple of 8; lanes = DATA_W/8.
- ADDR_W, 18, address width.
- DEPTH, 2048, number of words; must be ≤ 2^ADDR_W.
- READ_LAT, 2, cycles from read request to data on bus; legal 1..4.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- SRAM_ADDR, in, ADDR_W, word address.
- SRAM_BE_N, in, DATA_W/8, active-low byte-lane enables; bit 0 = DQ[7:0]. Generalises UB/LB.
- SRAM_WE_N, in, 1, active-low write enable.
- SRAM_CE_N, in, 1, active-low chip enable.
- SRAM_OE_N, in, 1, active-low output enable.
- SRAM_DQ, inout, DATA_W, bidirectional data bus.
- rd_valid, out, 1, high in the cycle read data is driven.
- oob, out, 1, one-cycle pulse for an access with SRAM_ADDR ≥ DEPTH.

## Operation
- **Request:** a request is sampled at posedge when SRAM_CE_N=0 and at least one SRAM_BE_N bit is 0. Otherwise the cycle is idle.
- **Write** (SRAM_WE_N=0):
  - Each enabled lane is written from SRAM_DQ; disabled lanes keep their old value.
  - The model never drives DQ in a write cycle, regardless of SRAM_OE_N. Write wins over OE.
- **Read** (SRAM_WE_N=1):
  - The full word and lane mask are captured at the request edge and pushed into a READ_LAT-deep pipeline.
  - One read may be accepted every cycle; reads are fully pipelined.
- **Drive rule:** at the pipeline output, lane i is driven only if:
  - stage valid = 1, and
  - the captured mask bit i is enabled, and
  - the current SRAM_OE_N = 0, and
  - the current cycle is not a write.
  
  All other lanes are high-Z.
- **rd_valid** = output stage valid, independent of OE.
- **Read-after-write:** a read captures memory at its request edge.
  - Same-edge write and read cannot coexist (a single port).
  - A write issued while an earlier read to the same address is in flight does not alter that read's data.
  - A read requested on the edge after a write returns the new data.
- **Out of range** (SRAM_ADDR ≥ DEPTH):
  - Writes are ignored.
  - Reads push data 0 with the normal mask and timing.
  - oob pulses high the cycle after the request edge.
- **Memory contents:** not cleared by reset; the initial contents are X.
- **Reset** (rst_n=0, asynchronous, including mid-read):
  - All pipeline valid bits are cleared, so in-flight reads are dropped.
  - rd_valid=0, oob=0, DQ high-Z immediately.
  - A write on the same edge as reset release is not performed.

## Timing
- Write: memory updated at the request posedge; visible to a read requested on the next posedge.
- Read latency: a request at edge N drives data from just after edge N+READ_LAT-1 until edge N+READ_LAT. The data is stable for one full cycle.
  - READ_LAT=1 matches the previous model.
- Back-to-back reads: one word per cycle, with no bubbles.
- A write following a read: the read's data still emerges on schedule. Its lanes are suppressed (tri-stated) in a cycle where a write is sampled; rd_valid still asserts.
- oob: registered, asserted for exactly one cycle per offending request.
- Reset values: rd_valid=0, oob=0, SRAM_DQ='z, all pipeline stages invalid.

## Structure
- A shared package holds:
  - localparam LANES = DATA_W/8;
  - the read-pipeline stage struct {valid, data[DATA_W], mask[LANES]};
  - the READ_LAT range check as an elaboration-time assertion.
- Sub-module sram_rd_pipe: a parametrised READ_LAT-stage shift register of stage structs with async reset of the valid bits only.
- The memory array, lane-masked write and tri-state drivers stay in the top.

## Test plan
- **Lane write:** DATA_W=16, write 16'hA5C3 to addr 5 with BE_N=2'b00, then 16'hFF11 with BE_N=2'b10, then read -> 16'hA511 after READ_LAT cycles, rd_valid high for 1 cycle.
- **Pipelined reads:** READ_LAT=3, preload addrs 0..3 with 16'h1000+i, read 0..3 on consecutive edges -> data 1000,1001,1002,1003 on 4 consecutive cycles starting 3 edges after the first request.
- **Partial lane read:** read with BE_N=2'b01 -> DQ[15:8]=data high byte, DQ[7:0]=z; with OE_N=1 -> all z, rd_valid still 1.
- **Hazard:** read addr 7 (holds 16'h0001), write 16'hBEEF to addr 7 next edge -> read returns 16'h0001; a subsequent read returns 16'hBEEF.
- **Out of range:** read/write addr 2048 with DEPTH=2048 -> oob pulses 1 cycle, the write leaves addrs 0 and 2047 unchanged, the read returns 16'h0000.
- **Reset mid-read:** assert rst_n=0 with 2 reads in flight -> DQ='z and rd_valid=0 immediately, no data emerges after release, and memory contents are preserved.
